// File: rtl/pulse_if.sv
// Button-side signal bundle for pulse_conditioner: raw button in, press pulse,
// debounced level and debug state out.
interface pulse_if;
  logic       btn;
  logic       w;
  logic       level;
  logic [1:0] state;

  modport master (output btn, input  w, level, state);
  modport slave  (input  btn, output w, level, state);
endinterface

// File: rtl/pulse_conditioner.sv
// Synchronises and debounces a raw push-button and emits one 1-cycle w pulse per clean press.
// Optional feature: define AUTOREPEAT_EN for held-button auto-repeat pulses.
module pulse_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_PERIOD   = 8,
  parameter int unsigned CNT_W           = 8
) (
  input  logic    clk,
  input  logic    rst,
  pulse_if.slave  p
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    CHK_PRESS = 2'b01,
    PRESSED   = 2'b10,
    CHK_REL   = 2'b11
  } state_t;

  localparam int unsigned MAX_LEN =
    (DEBOUNCE_CYCLES > REPEAT_DELAY)
      ? ((DEBOUNCE_CYCLES > REPEAT_PERIOD) ? DEBOUNCE_CYCLES : REPEAT_PERIOD)
      : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

  if (DEBOUNCE_CYCLES < 2 || CNT_W < $clog2(MAX_LEN + 1)) begin : g_cfg_bad
    $error("pulse_conditioner: DEBOUNCE_CYCLES must be >= 2 and CNT_W must hold all counts");
  end

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           st, st_nx;
  logic             s1, btn_s;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             w_q, w_nx;
  logic             level_q, level_nx;

`ifdef AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rc, rc_nx;
  logic             rep, rep_nx;  // set once the first repeat has fired
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      s1    <= p.btn;
      btn_s <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      cnt     <= '0;
      w_q     <= 1'b0;
      level_q <= 1'b0;
`ifdef AUTOREPEAT_EN
      rc      <= '0;
      rep     <= 1'b0;
`endif
    end else begin
      st      <= st_nx;
      cnt     <= cnt_nx;
      w_q     <= w_nx;
      level_q <= level_nx;
`ifdef AUTOREPEAT_EN
      rc      <= rc_nx;
      rep     <= rep_nx;
`endif
    end
  end

  always_comb begin
    st_nx    = st;
    cnt_nx   = cnt;
    w_nx     = 1'b0;
    level_nx = level_q;
`ifdef AUTOREPEAT_EN
    rc_nx    = rc;
    rep_nx   = rep;
`endif
    unique case (st)
      IDLE: begin
        if (btn_s) begin
          st_nx  = CHK_PRESS;
          cnt_nx = CNT_W'(1);
        end
      end
      CHK_PRESS: begin
        if (!btn_s) begin
          st_nx  = IDLE;
          cnt_nx = '0;
        end else if (cnt == DB_LAST) begin
          st_nx    = PRESSED;
          cnt_nx   = '0;
          level_nx = 1'b1;
          w_nx     = 1'b1;
`ifdef AUTOREPEAT_EN
          rc_nx    = '0;
          rep_nx   = 1'b0;
`endif
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          st_nx  = CHK_REL;
          cnt_nx = CNT_W'(1);
`ifdef AUTOREPEAT_EN
          rc_nx  = '0;
          rep_nx = 1'b0;
`endif
        end
`ifdef AUTOREPEAT_EN
        // Fire on the edge where rc would reach the threshold, so the pulse lands
        // exactly REPEAT_DELAY / REPEAT_PERIOD edges after the previous one.
        else if (rc == (rep ? RP_LAST : RD_LAST)) begin
          w_nx   = 1'b1;
          rc_nx  = '0;
          rep_nx = 1'b1;
        end else begin
          rc_nx = rc + CNT_W'(1);
        end
`endif
      end
      CHK_REL: begin
        if (btn_s) begin
          st_nx  = PRESSED;
          cnt_nx = '0;
        end else if (cnt == DB_LAST) begin
          st_nx    = IDLE;
          cnt_nx   = '0;
          level_nx = 1'b0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        st_nx  = IDLE;
        cnt_nx = '0;
      end
    endcase
  end

  assign p.w     = w_q;
  assign p.level = level_q;
  assign p.state = st;

endmodule

// File: tb/tb_pulse_conditioner.sv
// Directed bench for pulse_conditioner (DEBOUNCE_CYCLES=4) with hand-derived edge timing.
module tb_pulse_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pulse_if pif ();

  pulse_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (16),
    .REPEAT_PERIOD  (8),
    .CNT_W          (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .p  (pif)
  );

  int checks = 0;
  int errors = 0;
  int npulse = 0;
  int dbl    = 0;
  logic       wprev = 1'b0;
  logic [2:0] ctr   = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1ns after the edge; tracks pulses and back-to-back highs.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pif.w === 1'b1) begin
      npulse++;
      ctr = ctr + 3'd1;
      if (wprev) dbl++;
    end
    wprev = pif.w;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    pif.btn = 1'b0;
    ticks(3);
    check("rst_w", {31'd0, pif.w}, 32'd0);
    check("rst_level", {31'd0, pif.level}, 32'd0);
    check("rst_state", {30'd0, pif.state}, 32'd0);
    rst = 1'b0;
    ticks(3);

    // 1: clean press, pulse after E0+5 (6th sampled tick), release level drop at R0+5
    npulse = 0;
    pif.btn = 1'b1;
    ticks(5);
    check("t1_w_early", {31'd0, pif.w}, 32'd0);
    check("t1_lvl_early", {31'd0, pif.level}, 32'd0);
    check("t1_state_chk", {30'd0, pif.state}, 32'd1);
    tick();
    check("t1_w", {31'd0, pif.w}, 32'd1);
    check("t1_lvl", {31'd0, pif.level}, 32'd1);
    check("t1_state_pr", {30'd0, pif.state}, 32'd2);
    tick();
    check("t1_w_drop", {31'd0, pif.w}, 32'd0);
    ticks(7);
    pif.btn = 1'b0;
    ticks(5);
    check("t1_lvl_hold", {31'd0, pif.level}, 32'd1);
    tick();
    check("t1_lvl_rel", {31'd0, pif.level}, 32'd0);
    check("t1_state_idle", {30'd0, pif.state}, 32'd0);
    check("t1_npulse", npulse, 32'd1);

    // 2: press bounce never completes debounce
    npulse = 0;
    pif.btn = 1'b1; tick();
    pif.btn = 1'b1; tick();
    pif.btn = 1'b0; tick();
    pif.btn = 1'b1; tick();
    pif.btn = 1'b1; tick();
    pif.btn = 1'b0; tick();
    ticks(6);
    check("t2_npulse", npulse, 32'd0);
    check("t2_lvl", {31'd0, pif.level}, 32'd0);
    check("t2_state", {30'd0, pif.state}, 32'd0);

    // 3: release bounce: low 2, high 3, then low
    pif.btn = 1'b1;
    ticks(6);
    check("t3_press_lvl", {31'd0, pif.level}, 32'd1);
    ticks(4);
    npulse = 0;
    pif.btn = 1'b0;
    ticks(2);
    check("t3_lvl_b1", {31'd0, pif.level}, 32'd1);
    pif.btn = 1'b1;
    ticks(3);
    check("t3_lvl_b2", {31'd0, pif.level}, 32'd1);
    check("t3_state_back", {30'd0, pif.state}, 32'd2);
    pif.btn = 1'b0;
    ticks(5);
    check("t3_lvl_hold", {31'd0, pif.level}, 32'd1);
    check("t3_state_rel", {30'd0, pif.state}, 32'd3);
    tick();
    check("t3_lvl_rel", {31'd0, pif.level}, 32'd0);
    check("t3_npulse", npulse, 32'd0);

    // 4: reset mid CHK_PRESS with cnt=2, button held through reset
    ticks(2);
    pif.btn = 1'b1;
    ticks(4);
    check("t4_state_pre", {30'd0, pif.state}, 32'd1);
    rst = 1'b1;
    #1;
    check("t4_rst_state", {30'd0, pif.state}, 32'd0);
    check("t4_rst_w", {31'd0, pif.w}, 32'd0);
    check("t4_rst_lvl", {31'd0, pif.level}, 32'd0);
    ticks(2);
    rst = 1'b0;
    npulse = 0;
    ticks(5);
    check("t4_w_early", {31'd0, pif.w}, 32'd0);
    tick();
    check("t4_w", {31'd0, pif.w}, 32'd1);
    check("t4_lvl", {31'd0, pif.level}, 32'd1);
    pif.btn = 1'b0;
    ticks(8);
    check("t4_npulse", npulse, 32'd1);
    check("t4_state", {30'd0, pif.state}, 32'd0);

    // 5: long hold; auto-repeat adds pulses at t0+16 then every 8 up to t0+56
    npulse = 0;
    pif.btn = 1'b1;
    ticks(60);
    pif.btn = 1'b0;
    ticks(10);
`ifdef AUTOREPEAT_EN
    check("t5_npulse", npulse, 32'd7);
`else
    check("t5_npulse", npulse, 32'd1);
`endif

    // 6: two clean presses separated by 8 low cycles drive a 3-bit counter 000 -> 010
    ctr = '0;
    npulse = 0;
    pif.btn = 1'b1;
    ticks(8);
    pif.btn = 1'b0;
    ticks(8);
    check("t6_gap_state", {30'd0, pif.state}, 32'd0);
    pif.btn = 1'b1;
    ticks(8);
    pif.btn = 1'b0;
    ticks(8);
    check("t6_ctr", {29'd0, ctr}, 32'd2);
    check("t6_npulse", npulse, 32'd2);

    // 7: reset while PRESSED drops level at once and exits without a pulse
    pif.btn = 1'b1;
    ticks(7);
    check("t7_lvl_pre", {31'd0, pif.level}, 32'd1);
    pif.btn = 1'b0;
    rst = 1'b1;
    #1;
    check("t7_rst_lvl", {31'd0, pif.level}, 32'd0);
    check("t7_rst_state", {30'd0, pif.state}, 32'd0);
    ticks(2);
    rst = 1'b0;
    npulse = 0;
    ticks(10);
    check("t7_npulse", npulse, 32'd0);
    check("t7_lvl", {31'd0, pif.level}, 32'd0);

    check("w_back_to_back", dbl, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
